// File: rtl/ram_rw_tester.sv
// ram_rw_tester: multi-channel SRAM write / read-back self-tester behind the USI CSR bus.
// A RUN 0->1 edge sweeps every enabled channel: a full write pass with the selected
// data pattern, then a read pass whose data is compared L cycles after each issue.
// Optional feature macro: RAM_TESTER_ERRLOG_EN adds the first-failure address log
// (ERRADRS) and the saturating mismatch counter (ERRCNT); without it both read 0.
//
// CSR handshake: there is no valid/ready pair. A CSR write takes effect at every rising
// edge where op==01 and the block id matches; a CSR read returns on oSUsiRd exactly one
// cycle after op==00 with a matching block id is presented.
module ram_rw_tester #(
  parameter logic [3:0] pAdrsMap      = 4'h3,
  parameter int         pRamAdrsWidth = 5,
  parameter int         pRamDqWidth   = 16,
  parameter int         pRamChNum     = 2,
  parameter int         pRdLatency    = 1
) (
  input  logic                               iSCLK,
  input  logic                               inSRST,
  input  logic [31:0]                        iSUsiWd,
  input  logic [31:0]                        iSUsiAdrs,
  output logic [31:0]                        oSUsiRd,
  output logic [pRamAdrsWidth-1:0]           oRamAdrs,
  output logic [pRamDqWidth-1:0]             oRamWd,
  input  logic [pRamChNum*pRamDqWidth-1:0]   iRamRd,
  output logic                               oRamWe,
  output logic [pRamChNum-1:0]               oRamCe,
  output logic                               oTestErr,
  output logic                               oDone,
  output logic                               oBusy
);

  localparam int cW  = pRamDqWidth;
  localparam int cAW = pRamAdrsWidth;
  localparam int cN  = pRamChNum;
  localparam int cL  = pRdLatency;
  localparam int cXW = (cW > cAW) ? cW : cAW;
  localparam logic [cAW-1:0] cLastAdrs = '1;

  // Galois (right-shift) feedback masks of maximal-length polynomials, indexed by width.
  function automatic logic [31:0] tapsFor(input int w);
    case (w)
      4:       tapsFor = 32'h0000_0009;
      5:       tapsFor = 32'h0000_0012;
      6:       tapsFor = 32'h0000_0021;
      7:       tapsFor = 32'h0000_0041;
      8:       tapsFor = 32'h0000_00B8;
      9:       tapsFor = 32'h0000_0110;
      10:      tapsFor = 32'h0000_0240;
      11:      tapsFor = 32'h0000_0500;
      12:      tapsFor = 32'h0000_0829;
      13:      tapsFor = 32'h0000_100D;
      14:      tapsFor = 32'h0000_2015;
      15:      tapsFor = 32'h0000_4001;
      16:      tapsFor = 32'h0000_B400;
      17:      tapsFor = 32'h0001_0004;
      18:      tapsFor = 32'h0002_0040;
      19:      tapsFor = 32'h0004_0023;
      20:      tapsFor = 32'h0008_0004;
      21:      tapsFor = 32'h0010_0002;
      22:      tapsFor = 32'h0020_0001;
      23:      tapsFor = 32'h0040_0010;
      24:      tapsFor = 32'h0080_000D;
      25:      tapsFor = 32'h0100_0004;
      26:      tapsFor = 32'h0200_0023;
      27:      tapsFor = 32'h0400_0013;
      28:      tapsFor = 32'h0800_0004;
      29:      tapsFor = 32'h1000_0002;
      30:      tapsFor = 32'h2000_0029;
      31:      tapsFor = 32'h4000_0004;
      default: tapsFor = 32'h8020_0003;
    endcase
  endfunction

  localparam logic [31:0]   cTaps32 = tapsFor(cW);
  localparam logic [cW-1:0] cTaps   = cTaps32[cW-1:0];

  function automatic logic [cW-1:0] lfsrStep(input logic [cW-1:0] s);
    lfsrStep = s[0] ? ((s >> 1) ^ cTaps) : (s >> 1);
  endfunction

  // Pattern for one address. In LFSR mode this is only the first word (seed, 0 -> 1);
  // later LFSR words come from stepping the previous word.
  function automatic logic [cW-1:0] patFor(input logic [1:0] mode, input logic [cW-1:0] seed,
                                           input logic [cAW-1:0] adrs);
    logic [cXW-1:0] adrsExt;
    logic [32:0]    sum;
    adrsExt = cXW'(adrs);
    sum     = 33'(seed) + 33'(adrs);
    case (mode)
      2'd0:    patFor = seed + adrsExt[cW-1:0];
      2'd1:    patFor = (seed == '0) ? {{(cW-1){1'b0}}, 1'b1} : seed;
      2'd2:    patFor = {{(cW-1){1'b0}}, 1'b1} << (sum % 33'(cW));
      default: patFor = adrsExt[cW-1:0];
    endcase
  endfunction

  typedef enum logic [2:0] {sIdle, sSel, sWrite, sRead, sDrain, sNext, sDone} state_t;

  state_t          state;
  logic [cW-1:0]   seedReg, seedL;
  logic [1:0]      modeReg, modeL;
  logic [cN-1:0]   chMaskReg, chMaskL, visited, remaining, pickOh;
  logic            ctrlRun;
  logic [2:0]      curCh, pickCh, drainCnt;
  logic [cW-1:0]   patReg, patFirst, patNext, rdSel;
  logic [cAW-1:0]  nextAdrs;
  logic            vPipe   [cL];
  logic [cW-1:0]   expPipe [cL];
  logic [2:0]      chPipe  [cL];
  logic            mismatch;
  logic [31:0]     errAdrsRd, errCntRd;

  logic [1:0]  usiOp;
  logic [3:0]  usiBlk;
  logic [15:0] usiReg;
  logic        csrWr, csrRd, clrNow, runEdge;
  logic        unusedBits;

  assign usiOp   = iSUsiAdrs[31:30];
  assign usiBlk  = iSUsiAdrs[19:16];
  assign usiReg  = iSUsiAdrs[15:0];
  assign csrWr   = (usiBlk == pAdrsMap) && (usiOp == 2'b01);
  assign csrRd   = (usiBlk == pAdrsMap) && (usiOp == 2'b00);
  assign clrNow  = csrWr && (usiReg == 16'h0011) && iSUsiWd[1];
  assign runEdge = csrWr && (usiReg == 16'h0011) && iSUsiWd[0] && !ctrlRun;
  assign unusedBits = ^{iSUsiWd, iSUsiAdrs[29:20]};

  assign remaining = chMaskL & ~visited;
  assign nextAdrs  = oRamAdrs + 1'b1;
  assign patFirst  = patFor(modeL, seedL, '0);
  assign patNext   = (modeL == 2'd1) ? lfsrStep(patReg) : patFor(modeL, seedL, nextAdrs);

  // Lowest-numbered enabled channel not yet tested, as index and one-hot.
  always_comb begin
    pickCh = '0;
    pickOh = '0;
    for (int c = cN - 1; c >= 0; c--) begin
      if (remaining[c]) pickCh = 3'(c);
    end
    for (int c = 0; c < cN; c++) begin
      pickOh[c] = (remaining != '0) && (pickCh == 3'(c));
    end
  end

  // Read data of the channel whose compare is due this cycle.
  always_comb begin
    rdSel = '0;
    for (int c = 0; c < cN; c++) begin
      if (chPipe[cL-1] == 3'(c)) rdSel = iRamRd[c*cW +: cW];
    end
  end

  assign mismatch = vPipe[cL-1] && (rdSel != expPipe[cL-1]);

  // CSR write registers; CHMASK resets to all channels enabled.
  always_ff @(posedge iSCLK) begin
    if (!inSRST) begin
      seedReg   <= '0;
      modeReg   <= '0;
      chMaskReg <= '1;
      ctrlRun   <= 1'b0;
    end else if (csrWr) begin
      case (usiReg)
        16'h0010: seedReg   <= iSUsiWd[cW-1:0];
        16'h0011: ctrlRun   <= iSUsiWd[0];
        16'h0012: modeReg   <= iSUsiWd[1:0];
        16'h0013: chMaskReg <= iSUsiWd[cN-1:0];
        default: ;
      endcase
    end
  end

  // Expected data, channel and valid travel alongside each read issue for L cycles.
  always_ff @(posedge iSCLK) begin
    if (!inSRST) begin
      for (int i = 0; i < cL; i++) begin
        vPipe[i]   <= 1'b0;
        expPipe[i] <= '0;
        chPipe[i]  <= '0;
      end
    end else begin
      vPipe[0]   <= (state == sRead);
      expPipe[0] <= patReg;
      chPipe[0]  <= curCh;
      for (int i = 1; i < cL; i++) begin
        vPipe[i]   <= vPipe[i-1];
        expPipe[i] <= expPipe[i-1];
        chPipe[i]  <= chPipe[i-1];
      end
    end
  end

  // Test sequencer: SEL -> WRITE -> READ -> DRAIN -> NEXT per channel, then DONE.
  // SRAM outputs are registered and always describe the current state's access.
  always_ff @(posedge iSCLK) begin
    if (!inSRST) begin
      state    <= sIdle;
      seedL    <= '0;
      modeL    <= '0;
      chMaskL  <= '0;
      visited  <= '0;
      curCh    <= '0;
      drainCnt <= '0;
      patReg   <= '0;
      oRamAdrs <= '0;
      oRamWd   <= '0;
      oRamWe   <= 1'b0;
      oRamCe   <= '0;
      oTestErr <= 1'b0;
      oDone    <= 1'b0;
      oBusy    <= 1'b0;
    end else begin
      case (state)
        sIdle: begin
          if (runEdge) begin
            state   <= sSel;
            oBusy   <= 1'b1;
            seedL   <= seedReg;
            modeL   <= modeReg;
            chMaskL <= chMaskReg;
            visited <= '0;
          end
        end
        sSel: begin
          if (remaining != '0) begin
            state    <= sWrite;
            curCh    <= pickCh;
            visited  <= visited | pickOh;
            oRamCe   <= pickOh;
            oRamWe   <= 1'b1;
            oRamAdrs <= '0;
            patReg   <= patFirst;
            oRamWd   <= patFirst;
          end else begin
            // done is raised here so it is visible as soon as DONE is entered
            state <= sDone;
            oDone <= 1'b1;
            oBusy <= 1'b0;
          end
        end
        sWrite: begin
          if (oRamAdrs == cLastAdrs) begin
            // read pass replays the pattern from the first word
            state    <= sRead;
            oRamWe   <= 1'b0;
            oRamWd   <= '0;
            oRamAdrs <= '0;
            patReg   <= patFirst;
          end else begin
            oRamAdrs <= nextAdrs;
            patReg   <= patNext;
            oRamWd   <= patNext;
          end
        end
        sRead: begin
          if (oRamAdrs == cLastAdrs) begin
            state    <= sDrain;
            oRamCe   <= '0;
            oRamAdrs <= '0;
            drainCnt <= '0;
          end else begin
            oRamAdrs <= nextAdrs;
            patReg   <= patNext;
          end
        end
        sDrain: begin
          if (drainCnt == 3'(cL - 1)) state <= sNext;
          else drainCnt <= drainCnt + 1'b1;
        end
        sNext:   state <= sSel;
        sDone:   state <= sIdle;
        default: state <= sIdle;
      endcase
      if (mismatch) oTestErr <= 1'b1;
      // CLR overrides a same-cycle mismatch or completion
      if (clrNow) begin
        oTestErr <= 1'b0;
        oDone    <= 1'b0;
      end
    end
  end

`ifdef RAM_TESTER_ERRLOG_EN
  logic [cAW-1:0] adrsPipe [cL];
  logic [7:0]     errCh;
  logic [cAW-1:0] errAdrsReg;
  logic [15:0]    errCnt;
  logic           errLogged;

  // Address of each read issue, delayed to line up with its compare.
  always_ff @(posedge iSCLK) begin
    if (!inSRST) begin
      for (int i = 0; i < cL; i++) adrsPipe[i] <= '0;
    end else begin
      adrsPipe[0] <= oRamAdrs;
      for (int i = 1; i < cL; i++) adrsPipe[i] <= adrsPipe[i-1];
    end
  end

  // First-mismatch capture and saturating mismatch count, both cleared by CLR.
  always_ff @(posedge iSCLK) begin
    if (!inSRST || clrNow) begin
      errCh      <= '0;
      errAdrsReg <= '0;
      errCnt     <= '0;
      errLogged  <= 1'b0;
    end else if (mismatch) begin
      if (!errLogged) begin
        errCh      <= 8'(chPipe[cL-1]);
        errAdrsReg <= adrsPipe[cL-1];
        errLogged  <= 1'b1;
      end
      if (errCnt != 16'hFFFF) errCnt <= errCnt + 16'd1;
    end
  end

  assign errAdrsRd = 32'({errCh, errAdrsReg});
  assign errCntRd  = 32'(errCnt);
`else
  assign errAdrsRd = '0;
  assign errCntRd  = '0;
`endif

  // Registered CSR read data; idle or foreign cycles return 0.
  always_ff @(posedge iSCLK) begin
    if (!inSRST) begin
      oSUsiRd <= '0;
    end else if (csrRd) begin
      case (usiReg)
        16'h0020: oSUsiRd <= {29'd0, oBusy, oDone, oTestErr};
        16'h0021: oSUsiRd <= errAdrsRd;
        16'h0022: oSUsiRd <= errCntRd;
        default:  oSUsiRd <= '0;
      endcase
    end else begin
      oSUsiRd <= '0;
    end
  end

endmodule

// File: tb/tb_ram_rw_tester.sv
// Testbench for ram_rw_tester at default parameters with a one-cycle-latency SRAM model.
module tb_ram_rw_tester;
  localparam int AW = 5;
  localparam int W  = 16;
  localparam int N  = 2;
  localparam int D  = 32;
  localparam logic [3:0]  BLK  = 4'h3;
  localparam logic [31:0] IDLE = 32'hC000_0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]    usi_wd, usi_adrs, usi_rd;
  logic [AW-1:0]  ram_adrs;
  logic [W-1:0]   ram_wd;
  logic [N*W-1:0] ram_rd;
  logic           ram_we, test_err, done, busy;
  logic [N-1:0]   ram_ce;

  ram_rw_tester dut (
    .iSCLK(clk), .inSRST(rst_n), .iSUsiWd(usi_wd), .iSUsiAdrs(usi_adrs), .oSUsiRd(usi_rd),
    .oRamAdrs(ram_adrs), .oRamWd(ram_wd), .iRamRd(ram_rd), .oRamWe(ram_we), .oRamCe(ram_ce),
    .oTestErr(test_err), .oDone(done), .oBusy(busy)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic [N+AW+W-1:0] wr_q[$];
  bit mon_wr_en = 1'b1;
  bit stuck_en = 1'b0;

  // SRAM model: registered read of every channel, optional stuck-at-1 on ch1 bit3 @ 0x07
  logic [W-1:0] mem [N][D];
  logic [W-1:0] rd  [N];
  initial begin
    for (int c = 0; c < N; c++) begin
      rd[c] = '0;
      for (int a = 0; a < D; a++) mem[c][a] = '0;
    end
  end
  always @(posedge clk) begin
    for (int c = 0; c < N; c++) begin
      rd[c] <= mem[c][ram_adrs] | ((stuck_en && c == 1 && ram_adrs == 5'h07) ? 16'h0008 : 16'h0000);
      if (ram_we && ram_ce[c]) mem[c][ram_adrs] <= ram_wd;
    end
  end
  assign ram_rd = {rd[1], rd[0]};

  // scoreboard monitor: CSR read data, one cycle after a read to this block
  logic rd_seen = 1'b0;
  logic [31:0] mon_e;
  string mon_nm;
  always @(posedge clk) rd_seen <= (usi_adrs[31:30] == 2'b00) && (usi_adrs[19:16] == BLK);
  always @(negedge clk) begin
    if (rd_seen) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL csr_unexpected got=%h", usi_rd);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_nm = nm_q.pop_front();
        if (usi_rd !== mon_e) begin
          bad++;
          $display("FAIL %s got=%h exp=%h", mon_nm, usi_rd, mon_e);
        end
      end
    end
  end

  // scoreboard monitor: every SRAM write beat {ce, adrs, data}
  logic [N+AW+W-1:0] mon_w;
  always @(negedge clk) begin
    if (mon_wr_en && ram_we && (ram_ce != '0)) begin
      total++;
      if (wr_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected got=%h", {ram_ce, ram_adrs, ram_wd});
      end else begin
        mon_w = wr_q.pop_front();
        if ({ram_ce, ram_adrs, ram_wd} !== mon_w) begin
          bad++;
          $display("FAIL sram_write got=%h exp=%h", {ram_ce, ram_adrs, ram_wd}, mon_w);
        end
      end
    end
  end

  // driver tasks
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic csr_wr(input logic [15:0] r, input logic [31:0] d);
    @(negedge clk);
    usi_adrs = {2'b01, 10'd0, BLK, r};
    usi_wd   = d;
    @(negedge clk);
    usi_adrs = IDLE;
  endtask

  task automatic csr_rd(input logic [15:0] r, input logic [31:0] exp, input string nm);
    @(negedge clk);
    usi_adrs = {2'b00, 10'd0, BLK, r};
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    @(negedge clk);
    usi_adrs = IDLE;
  endtask

  task automatic push_wr(input logic [N-1:0] ce, input int a, input logic [W-1:0] d);
    wr_q.push_back({ce, 5'(a), d});
  endtask

  // CTRL=3 (CLR + RUN edge) in cycle 0, CTRL=1 in cycle 1, then count to done.
  task automatic run_test(input int exp_cyc, input string nm, output logic [N-1:0] ce_or);
    int n;
    ce_or = '0;
    @(negedge clk);
    usi_adrs = {2'b01, 10'd0, BLK, 16'h0011};
    usi_wd   = 32'd3;
    @(negedge clk);
    n = 1;
    check({nm, "_busy"}, {31'd0, busy}, 32'd1);
    usi_wd = 32'd1;
    ce_or |= ram_ce;
    @(negedge clk);
    n = 2;
    usi_adrs = IDLE;
    ce_or |= ram_ce;
    while (!done && n < exp_cyc + 50) begin
      @(negedge clk);
      n++;
      ce_or |= ram_ce;
    end
    check({nm, "_done_cycle"}, 32'(n), 32'(exp_cyc));
  endtask

  task automatic check_outputs_zero(input string nm);
    check({nm, "_usi_rd"}, usi_rd, 32'd0);
    check({nm, "_ram_adrs"}, 32'(ram_adrs), 32'd0);
    check({nm, "_ram_wd"}, 32'(ram_wd), 32'd0);
    check({nm, "_ram_we_ce"}, {29'd0, ram_we, ram_ce}, 32'd0);
    check({nm, "_flags"}, {29'd0, busy, done, test_err}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  logic [N-1:0] ce_seen;
  logic [15:0]  s;

  initial begin
    usi_adrs = IDLE;
    usi_wd   = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    csr_rd(16'h0020, 32'h0, "reset_status");
    csr_rd(16'h0021, 32'h0, "reset_erradrs");
    csr_rd(16'h0022, 32'h0, "reset_errcnt");
    csr_rd(16'h0030, 32'h0, "unmapped_reg");

    // increment mode, both channels
    csr_wr(16'h0011, 32'd2);
    csr_wr(16'h0010, 32'h35);
    csr_wr(16'h0012, 32'd0);
    for (int c = 0; c < N; c++)
      for (int a = 0; a < D; a++) push_wr(2'(1 << c), a, 16'h0035 + 16'(a));
    run_test(136, "incr", ce_seen);
    csr_rd(16'h0020, 32'h2, "incr_status");
    csr_rd(16'h0022, 32'h0, "incr_errcnt");

    // stuck bit on ch1 address 0x07
    csr_wr(16'h0011, 32'd2);
    csr_wr(16'h0010, 32'h0);
    stuck_en = 1'b1;
    for (int c = 0; c < N; c++)
      for (int a = 0; a < D; a++) push_wr(2'(1 << c), a, 16'(a));
    run_test(136, "stuck", ce_seen);
    stuck_en = 1'b0;
    check("stuck_err_pin", {31'd0, test_err}, 32'd1);
    csr_rd(16'h0020, 32'h3, "stuck_status");
`ifdef RAM_TESTER_ERRLOG_EN
    csr_rd(16'h0021, 32'h27, "stuck_erradrs");
    csr_rd(16'h0022, 32'h1, "stuck_errcnt");
`else
    csr_rd(16'h0021, 32'h0, "stuck_erradrs");
    csr_rd(16'h0022, 32'h0, "stuck_errcnt");
`endif

    // LFSR mode, seed 0 forced to 1; both channels replay the same sequence
    csr_wr(16'h0011, 32'd2);
    csr_wr(16'h0012, 32'd1);
    for (int c = 0; c < N; c++) begin
      push_wr(2'(1 << c), 0, 16'h0001);
      push_wr(2'(1 << c), 1, 16'hB400);
      s = 16'hB400;
      for (int a = 2; a < D; a++) begin
        s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
        push_wr(2'(1 << c), a, s);
      end
    end
    run_test(136, "lfsr", ce_seen);
    csr_rd(16'h0020, 32'h2, "lfsr_status");

    // channel 1 only, walking one with seed 3
    csr_wr(16'h0011, 32'd2);
    csr_wr(16'h0013, 32'd2);
    csr_wr(16'h0012, 32'd2);
    csr_wr(16'h0010, 32'd3);
    push_wr(2'b10, 0, 16'h0008);
    for (int a = 1; a < D; a++) push_wr(2'b10, a, 16'(1 << ((a + 3) % 16)));
    run_test(69, "walk", ce_seen);
    check("walk_ce_seen", 32'(ce_seen), 32'h2);
    csr_rd(16'h0020, 32'h2, "walk_status");

    // empty mask
    csr_wr(16'h0011, 32'd2);
    csr_wr(16'h0013, 32'd0);
    run_test(2, "nomask", ce_seen);
    check("nomask_ce_seen", 32'(ce_seen), 32'h0);
    csr_rd(16'h0020, 32'h2, "nomask_status");

    // abort by reset at cycle 20 of a running test
    csr_wr(16'h0011, 32'd2);
    csr_wr(16'h0013, 32'd3);
    csr_wr(16'h0012, 32'd0);
    mon_wr_en = 1'b0;
    @(negedge clk);
    usi_adrs = {2'b01, 10'd0, BLK, 16'h0011};
    usi_wd   = 32'd1;
    @(negedge clk);
    usi_adrs = IDLE;
    repeat (19) @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("abort");
    rst_n = 1'b1;
    mon_wr_en = 1'b1;
    @(negedge clk);

    // reach done, then CLR returns STATUS to 0
    csr_wr(16'h0013, 32'd0);
    run_test(2, "post_abort", ce_seen);
    check("post_abort_done", {31'd0, done}, 32'd1);
    csr_wr(16'h0011, 32'd2);
    csr_rd(16'h0020, 32'h0, "clr_status");
    repeat (2) @(negedge clk);

    total++;
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      bad++;
      $display("FAIL queues_drained got=%0d exp=0", exp_q.size() + wr_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_rw_tester.md
# ram_rw_tester

Parametrised multi-channel SRAM read/write self-tester, the next-generation replacement for the fixed two-chip tester inside the RAM block. It is configured over the USI CSR bus and sweeps every enabled channel's full address space: a write pass with a selectable data pattern, then a read-back and compare pass. It reports pass/fail, busy and done, and optionally the first failing address and an error count.

## Interface
Parameters:
- pAdrsMap, 4'h3, USI block ID this tester answers to
- pRamAdrsWidth, 5, SRAM address width; depth D = 2^pRamAdrsWidth
- pRamDqWidth, 16, SRAM data width W (4..32)
- pRamChNum, 2, number of SRAM channels N (1..8)
- pRdLatency, 1, SRAM read latency L in cycles (1..4)

Ports:
- iSCLK  in  1  system clock; everything is on the rising edge
- inSRST  in  1  reset; synchronous, active-low
- iSUsiWd  in  32  CSR write data
- iSUsiAdrs  in  32  CSR address: {op[1:0], 10'd0, block_id[3:0], reg[15:0]}; op 2'b01 = write, 2'b00 = read
- oSUsiRd  out  32  CSR read data, registered
- oRamAdrs  out  pRamAdrsWidth  SRAM address, shared by all channels
- oRamWd  out  W  SRAM write data
- iRamRd  in  N*W  SRAM read data; channel c occupies [c*W +: W]
- oRamWe  out  1  write enable, active-high
- oRamCe  out  N  per-channel chip enable, active-high, one-hot
- oTestErr  out  1  sticky mismatch flag
- oDone  out  1  sticky test-complete flag
- oBusy  out  1  test in progress

## Operation
- **CSR write:** performed on every cycle in which op == 2'b01 and block_id == pAdrsMap. A held address re-writes the same value, which is harmless.
- **Write registers:**
  - 0x10 SEED[W-1:0]
  - 0x11 CTRL: bit0 RUN, bit1 CLR
  - 0x12 MODE[1:0]
  - 0x13 CHMASK[N-1:0]; reset value is all ones
- **Read registers:**
  - 0x20 STATUS {29'd0, busy, done, err}
  - 0x21 ERRADRS {ch[7:0], adrs}
  - 0x22 ERRCNT[15:0]
  - Any other register reads 0.
- **CLR:** bit1 = 1 clears err, done, ERRADRS and ERRCNT on every cycle it is held.
- **Start:** a 0->1 edge on RUN starts a test, only when in IDLE. RUN edges are ignored when not in IDLE.
- **State machine:** IDLE -> SEL -> WRITE -> READ -> DRAIN -> NEXT -> (SEL or DONE).
  - SEL (1 cycle) picks the lowest unvisited channel whose CHMASK bit is set. If none remains, it goes to DONE.
  - WRITE: D cycles; oRamCe[c]=1, oRamWe=1, oRamAdrs = 0..D-1, oRamWd = pattern(adrs).
  - READ: D cycles; oRamWe=0, issue addresses 0..D-1.
  - DRAIN: L cycles.
  - NEXT: 1 cycle.
  - DONE: sets done, clears busy, returns to IDLE.
- **Compare:** the expected value is delayed L cycles alongside the address. iRamRd[c] is compared L cycles after each read issue. Any mismatch sets err.
- **Patterns, by MODE:**
  - 0: SEED + adrs, mod 2^W
  - 1: LFSR. Galois, taps from the primitive polynomial for W (W=16: x^16+x^14+x^13+x^11+1). Loaded with SEED at SEL (0 is forced to 1) and stepped once per word; the read pass reloads the LFSR and replays the sequence.
  - 2: walking one, 1 << ((adrs + SEED) mod W)
  - 3: address-as-data, zero-extended or truncated to W
- **CHMASK = 0:** RUN edge -> SEL -> DONE, with err = 0.
- **CSR changes during a test:** SEED, MODE and CHMASK are sampled at the RUN edge; later writes do not affect the running test.

## Timing
- **Reset values:** all outputs are 0 (oSUsiRd, oRamAdrs, oRamWd, oRamWe, oRamCe, oTestErr, oDone, oBusy), and the state is IDLE.
- **Reset mid-test:** aborts immediately; all state returns to reset values.
- **Busy:** asserted the cycle after the RUN edge.
- **Done latency:** done asserts M*(2D + L + 2) + 2 cycles after the RUN edge cycle, where M is the number of enabled channels.
- **CSR read:** data is valid on oSUsiRd 1 cycle after the read address is presented.
- **Clear/error collision:** if CLR and a mismatch occur in the same cycle, CLR wins.
- **Counter saturation:** ERRCNT saturates at 0xFFFF.

## Configuration
- **RAM_TESTER_ERRLOG_EN defined:**
  - ERRADRS captures the channel and address of the first mismatch since the last CLR.
  - ERRCNT counts every mismatch.
- **RAM_TESTER_ERRLOG_EN undefined:**
  - The log logic is removed and 0x21/0x22 read 0.
  - err/done behaviour is unchanged.

## Test plan
Default parameters (D=32, W=16, N=2, L=1) and an ideal SRAM model.
- **Increment mode:** CLR (write CTRL=2), SEED=0x35, MODE=0, CTRL=3 then 1 -> each channel is written 0x35..0x54; done after 2*(64+3)+2 = 136 cycles; err = 0.
- **Stuck bit, log enabled:** model ch1 bit3 stuck-at-1 at address 0x07, SEED=0x00, MODE=0 -> err = 1, ERRADRS = {8'd1, 5'h07}, ERRCNT = 1.
- **LFSR mode:** MODE=1, SEED=0 -> first word written is 0x0001, second is the LFSR's next state; err = 0.
- **Mask and walking one:** CHMASK=2'b10, MODE=2, SEED=3 -> only oRamCe[1] ever asserts; address 0 is written 0x0008; done after 69 cycles.
- **CHMASK=0:** RUN edge -> done on cycle 2; oRamCe stays 0 throughout.
- **Abort and clear:** drop inSRST at cycle 20 of a test -> all outputs are 0 on the next cycle. Then CLR while done = 1 -> STATUS reads 0.
